// File: rtl/kdtree_load_ctrl.sv
// kdtree_load_ctrl: splits the input FIFO word stream into node, leaf
// and query record writes after a load_kdtree pulse.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   load_kdtree      start pulse (honoured only when idle)
//   fifo_rdata/rempty_n/deq  FWFT FIFO read side
//   node_*           internal node write {median, split index}
//   leaf_*           leaf patch write (leaf, slot, patch, image index)
//   query_*          query patch write
//   busy, load_done, kdtree_loaded  status
module kdtree_load_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494,
  parameter int NODE_AW    = $clog2(NUM_LEAVES),
  parameter int QUERY_AW   = $clog2(NUM_QUERYS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_kdtree,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  input  logic                             fifo_rempty_n,
  output logic                             fifo_deq,
  output logic                             node_wen,
  output logic [NODE_AW-1:0]               node_waddr,
  output logic [2*DATA_WIDTH-1:0]          node_wdata,
  output logic                             leaf_wen,
  output logic [NODE_AW-1:0]               leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]     leaf_wsel,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wdata,
  output logic [DATA_WIDTH-1:0]            leaf_widx,
  output logic                             query_wen,
  output logic [QUERY_AW-1:0]              query_waddr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wdata,
  output logic                             busy,
  output logic                             load_done,
  output logic                             kdtree_loaded
);

  localparam int WSW = $clog2(LEAF_SIZE);
  localparam int WCW = $clog2(PATCH_SIZE+1);
  localparam int PW  = PATCH_SIZE*DATA_WIDTH;

  localparam logic [WCW-1:0] WC_NODE_LAST =
    WCW'(1);
  localparam logic [WCW-1:0] WC_LEAF_LAST =
    WCW'(PATCH_SIZE);
  localparam logic [WCW-1:0] WC_QRY_LAST =
    WCW'(PATCH_SIZE-1);
  localparam logic [NODE_AW-1:0] NODE_END =
    NODE_AW'(NUM_LEAVES-2);
  localparam logic [NODE_AW-1:0] LEAF_END =
    NODE_AW'(NUM_LEAVES-1);
  localparam logic [WSW-1:0] SLOT_END =
    WSW'(LEAF_SIZE-1);
  localparam logic [QUERY_AW-1:0] QRY_END =
    QUERY_AW'(NUM_QUERYS-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NODES,
    S_LEAVES,
    S_QUERIES
  } state_t;

  state_t state, state_nx;

  logic [WCW-1:0]        word_cnt;
  logic [NODE_AW-1:0]    node_cnt;
  logic [NODE_AW-1:0]    leaf_cnt;
  logic [WSW-1:0]        slot_cnt;
  logic [QUERY_AW-1:0]   query_cnt;
  logic [DATA_WIDTH-1:0] node_idx;
  logic [PW-1:0]         patch_buf;
  logic [PW-1:0]         q_data;
  logic                  rec_last;
  logic                  sec_end;
  logic                  start;

  assign fifo_deq = (state != S_IDLE) & fifo_rempty_n;
  assign start    = (state == S_IDLE) & load_kdtree;

  always_comb begin
    rec_last = 1'b0;
    sec_end  = 1'b0;
    unique case (state)
      S_NODES: begin
        rec_last = (word_cnt == WC_NODE_LAST);
        sec_end  = (node_cnt == NODE_END);
      end
      S_LEAVES: begin
        rec_last = (word_cnt == WC_LEAF_LAST);
        sec_end  = (leaf_cnt == LEAF_END) &&
                   (slot_cnt == SLOT_END);
      end
      S_QUERIES: begin
        rec_last = (word_cnt == WC_QRY_LAST);
        sec_end  = (query_cnt == QRY_END);
      end
      default: ;
    endcase
  end

  // Last query word bypasses the buffer so the write lands one
  // cycle after it is accepted.
  always_comb begin
    q_data = patch_buf;
    q_data[(PATCH_SIZE-1)*DATA_WIDTH +: DATA_WIDTH] =
      fifo_rdata;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (load_kdtree) state_nx = S_NODES;
      end
      S_NODES: begin
        if (fifo_deq && rec_last && sec_end)
          state_nx = S_LEAVES;
      end
      S_LEAVES: begin
        if (fifo_deq && rec_last && sec_end)
          state_nx = S_QUERIES;
      end
      S_QUERIES: begin
        if (fifo_deq && rec_last && sec_end)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt      <= '0;
      node_cnt      <= '0;
      leaf_cnt      <= '0;
      slot_cnt      <= '0;
      query_cnt     <= '0;
      node_idx      <= '0;
      patch_buf     <= '0;
      node_wen      <= 1'b0;
      node_waddr    <= '0;
      node_wdata    <= '0;
      leaf_wen      <= 1'b0;
      leaf_waddr    <= '0;
      leaf_wsel     <= '0;
      leaf_wdata    <= '0;
      leaf_widx     <= '0;
      query_wen     <= 1'b0;
      query_waddr   <= '0;
      query_wdata   <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      kdtree_loaded <= 1'b0;
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      load_done <= 1'b0;
      if (start) begin
        word_cnt      <= '0;
        node_cnt      <= '0;
        leaf_cnt      <= '0;
        slot_cnt      <= '0;
        query_cnt     <= '0;
        busy          <= 1'b1;
        kdtree_loaded <= 1'b0;
      end else if (fifo_deq) begin
        unique case (state)
          S_NODES: begin
            if (rec_last) begin
              node_wen   <= 1'b1;
              node_waddr <= node_cnt;
              node_wdata <= {fifo_rdata, node_idx};
              word_cnt   <= '0;
              if (!sec_end)
                node_cnt <= node_cnt + 1'b1;
            end else begin
              node_idx <= fifo_rdata;
              word_cnt <= word_cnt + 1'b1;
            end
          end
          S_LEAVES: begin
            if (rec_last) begin
              leaf_wen   <= 1'b1;
              leaf_waddr <= leaf_cnt;
              leaf_wsel  <= slot_cnt;
              leaf_wdata <= patch_buf;
              leaf_widx  <= fifo_rdata;
              word_cnt   <= '0;
              if (slot_cnt == SLOT_END) begin
                slot_cnt <= '0;
                if (!sec_end)
                  leaf_cnt <= leaf_cnt + 1'b1;
              end else begin
                slot_cnt <= slot_cnt + 1'b1;
              end
            end else begin
              patch_buf[word_cnt*DATA_WIDTH +: DATA_WIDTH]
                <= fifo_rdata;
              word_cnt <= word_cnt + 1'b1;
            end
          end
          S_QUERIES: begin
            if (rec_last) begin
              query_wen   <= 1'b1;
              query_waddr <= query_cnt;
              query_wdata <= q_data;
              word_cnt    <= '0;
              if (sec_end) begin
                load_done     <= 1'b1;
                kdtree_loaded <= 1'b1;
                busy          <= 1'b0;
              end else begin
                query_cnt <= query_cnt + 1'b1;
              end
            end else begin
              patch_buf[word_cnt*DATA_WIDTH +: DATA_WIDTH]
                <= fifo_rdata;
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kdtree_load_ctrl.sv
// tb_kdtree_load_ctrl: random stream bench for kdtree_load_ctrl with
// an index-arithmetic reference model of the record layout.
module tb_kdtree_load_ctrl;

  localparam int DW  = 11;
  localparam int PS  = 5;
  localparam int LS  = 8;
  localparam int NL  = 64;
  localparam int NQ  = 494;
  localparam int NAW = 6;
  localparam int QAW = 9;
  localparam int PW  = PS*DW;
  localparam int NNODE  = NL-1;
  localparam int NLEAFP = NL*LS;
  localparam int LEAF_BASE  = 2*NNODE;
  localparam int QUERY_BASE = LEAF_BASE + NLEAFP*(PS+1);
  localparam int NWORDS = QUERY_BASE + NQ*PS;
  localparam int LEN = NWORDS + 8;

  logic clk, rst_n, load_kdtree;
  logic [DW-1:0] fifo_rdata;
  logic fifo_rempty_n, fifo_deq;
  logic node_wen;
  logic [NAW-1:0] node_waddr;
  logic [2*DW-1:0] node_wdata;
  logic leaf_wen;
  logic [NAW-1:0] leaf_waddr;
  logic [2:0] leaf_wsel;
  logic [PW-1:0] leaf_wdata;
  logic [DW-1:0] leaf_widx;
  logic query_wen;
  logic [QAW-1:0] query_waddr;
  logic [PW-1:0] query_wdata;
  logic busy, load_done, kdtree_loaded;

  kdtree_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_kdtree(load_kdtree),
    .fifo_rdata(fifo_rdata),
    .fifo_rempty_n(fifo_rempty_n),
    .fifo_deq(fifo_deq),
    .node_wen(node_wen), .node_waddr(node_waddr),
    .node_wdata(node_wdata),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr),
    .leaf_wsel(leaf_wsel), .leaf_wdata(leaf_wdata),
    .leaf_widx(leaf_widx),
    .query_wen(query_wen), .query_waddr(query_waddr),
    .query_wdata(query_wdata),
    .busy(busy), .load_done(load_done),
    .kdtree_loaded(kdtree_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] stream [0:LEN-1];
  int n_checks, n_errors;
  int ptr, duty, cyc;
  int node_seen, leaf_seen, query_seen, done_seen;
  int load_cyc, done_cyc;
  bit deq_pending, load_req, pending_start, tb_busy;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [PW-1:0] e;
    int b;
    @(negedge clk);
    if (deq_pending) ptr++;
    if (pending_start) begin
      tb_busy = 1'b1;
      check("loaded_clr", 64'(kdtree_loaded), 64'd0);
    end
    pending_start = 1'b0;
    check("one_wen",
      64'($countones({node_wen, leaf_wen, query_wen}) > 1),
      64'd0);
    if (node_wen) begin
      if (node_seen < NNODE) begin
        b = 2*node_seen;
        check("node_addr", 64'(node_waddr),
              64'(node_seen));
        check("node_data", 64'(node_wdata),
              64'({stream[b+1], stream[b]}));
      end else check("node_extra", 64'd1, 64'd0);
      node_seen++;
    end
    if (leaf_wen) begin
      if (leaf_seen < NLEAFP) begin
        b = LEAF_BASE + (PS+1)*leaf_seen;
        for (int k = 0; k < PS; k++)
          e[k*DW +: DW] = stream[b+k];
        check("leaf_addr", 64'(leaf_waddr),
              64'(leaf_seen / LS));
        check("leaf_sel", 64'(leaf_wsel),
              64'(leaf_seen % LS));
        check("leaf_data", 64'(leaf_wdata), 64'(e));
        check("leaf_idx", 64'(leaf_widx),
              64'(stream[b+PS]));
      end else check("leaf_extra", 64'd1, 64'd0);
      leaf_seen++;
    end
    if (query_wen) begin
      if (query_seen < NQ) begin
        b = QUERY_BASE + PS*query_seen;
        for (int k = 0; k < PS; k++)
          e[k*DW +: DW] = stream[b+k];
        check("query_addr", 64'(query_waddr),
              64'(query_seen));
        check("query_data", 64'(query_wdata), 64'(e));
      end else check("query_extra", 64'd1, 64'd0);
      query_seen++;
    end
    if (load_done) begin
      done_seen++;
      done_cyc = cyc;
      tb_busy = 1'b0;
      check("done_qwen", 64'(query_wen), 64'd1);
      check("done_qcount", 64'(query_seen), 64'(NQ));
      check("done_loaded", 64'(kdtree_loaded), 64'd1);
    end
    check("busy", 64'(busy), 64'(tb_busy));
    load_kdtree = load_req;
    if (load_req && !tb_busy) begin
      pending_start = 1'b1;
      load_cyc = cyc;
    end
    load_req = 1'b0;
    fifo_rempty_n = (ptr < LEN) &&
                    ($urandom_range(0, 99) < duty);
    fifo_rdata = (ptr < LEN) ? stream[ptr] : '0;
    #1;
    check("deq_empty", 64'(fifo_deq & ~fifo_rempty_n),
          64'd0);
    if (load_done)
      check("deq_after_done", 64'(fifo_deq), 64'd0);
    deq_pending = fifo_deq;
    cyc++;
  endtask

  task automatic run_load(input int d, input int mid_at,
                          input int abort_at,
                          input int budget);
    bit pulsed;
    pulsed = 1'b0;
    ptr = 0;
    node_seen = 0;
    leaf_seen = 0;
    query_seen = 0;
    done_seen = 0;
    duty = d;
    load_req = 1'b1;
    for (int i = 0; i < budget && done_seen == 0; i++) begin
      tick();
      if (mid_at > 0 && !pulsed && ptr >= mid_at) begin
        load_req = 1'b1;
        pulsed = 1'b1;
      end
      if (abort_at > 0 && ptr >= abort_at) return;
    end
    check("done_seen", 64'(done_seen), 64'd1);
    check("node_count", 64'(node_seen), 64'(NNODE));
    check("leaf_count", 64'(leaf_seen), 64'(NLEAFP));
    check("query_count", 64'(query_seen), 64'(NQ));
    check("words_used", 64'(ptr), 64'(NWORDS));
    if (d == 100)
      check("done_latency", 64'(done_cyc - load_cyc),
            64'(NWORDS + 1));
    repeat (4) tick();
    check("done_once", 64'(done_seen), 64'd1);
    check("idle_no_pop", 64'(ptr), 64'(NWORDS));
    check("loaded_sticky", 64'(kdtree_loaded), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'(|{fifo_deq, node_wen, node_waddr,
                     node_wdata, leaf_wen, leaf_waddr,
                     leaf_wsel, leaf_wdata, leaf_widx,
                     query_wen, query_waddr, query_wdata,
                     busy, load_done, kdtree_loaded}),
          64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    ptr = 0;
    duty = 100;
    deq_pending = 1'b0;
    load_req = 1'b0;
    pending_start = 1'b0;
    tb_busy = 1'b0;
    rst_n = 1'b0;
    load_kdtree = 1'b0;
    fifo_rempty_n = 1'b0;
    fifo_rdata = '0;
    for (int i = 0; i < LEN; i++)
      stream[i] = DW'($urandom_range(0, 2047));
    stream[0] = 11'd3;
    stream[1] = 11'd120;
    for (int k = 0; k < PS; k++)
      stream[LEAF_BASE + (PS+1)*15 + k] = DW'(10 + k);
    stream[LEAF_BASE + (PS+1)*15 + PS] = 11'd999;

    repeat (3) @(negedge clk);
    fifo_rempty_n = 1'b1;
    fifo_rdata = stream[0];
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    run_load(100, 0, 0, 7000);
    run_load(30, 2000, 0, 40000);

    run_load(100, 0, 1000, 2000);
    rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    check("reset_loaded", 64'(kdtree_loaded), 64'd0);
    deq_pending = 1'b0;
    pending_start = 1'b0;
    tb_busy = 1'b0;
    load_req = 1'b0;
    load_kdtree = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_load(100, 0, 0, 7000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
